// File: rtl/sub_pipe.sv
// Pipelined subtractor Result = in_A - in_B, one SEG-bit segment per stage; latency STAGES falling edges.
// stall freezes every register (DV0 ignored); flags are recomputed only when a valid slot reaches the output.
module sub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DV0,
  input  logic             stall,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             borrow,
  output logic             lt,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;

  // Stage k adds segment k. Operand bits above it are delayed, and finished
  // result bits below it are delayed, so every segment reaches the output together.
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [WIDTH-1:LO] a;
    logic [WIDTH-1:LO] b;
    logic [HI-1:0]     r;
    logic              c_in;
    logic              m;
    logic              v;
    logic [SEG:0]      sum;

    assign sum = {1'b0, a[LO +: SEG]} + {1'b0, ~b[LO +: SEG]} + {{SEG{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign a    = in_A;
      assign b    = in_B;
      assign c_in = 1'b1;
      assign m    = signed_mode;
      assign v    = DV0;
      assign r    = sum[SEG-1:0];
    end else begin : g_src
      assign a    = g_stage[k-1].g_reg.a_q;
      assign b    = g_stage[k-1].g_reg.b_q;
      assign c_in = g_stage[k-1].g_reg.c_q;
      assign m    = g_stage[k-1].g_reg.m_q;
      assign v    = g_stage[k-1].g_reg.v_q;
      assign r    = {sum[SEG-1:0], g_stage[k-1].g_reg.r_q};
    end

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      logic [HI-1:0]     r_q;
      logic              c_q;
      logic              m_q;
      logic              v_q;

      // The divider datapath registers on the falling edge.
      always_ff @(negedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          m_q <= 1'b0;
          v_q <= 1'b0;
        end else if (!stall) begin
          a_q <= a[WIDTH-1:HI];
          b_q <= b[WIDTH-1:HI];
          r_q <= r;
          c_q <= sum[SEG];
          m_q <= m;
          v_q <= v;
        end
      end
    end else begin : g_out
      logic a_n;
      logic b_n;
      logic r_n;
      logic v_ovf;

      assign a_n   = a[WIDTH-1];
      assign b_n   = b[WIDTH-1];
      assign r_n   = r[WIDTH-1];
      assign v_ovf = (a_n ^ b_n) & (r_n ^ a_n);

      always_ff @(negedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          Result    <= '0;
          borrow    <= 1'b0;
          lt        <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (!stall) begin
          out_valid <= v;
          // Bubbles leave the last valid result and flags in place.
          if (v) begin
            Result <= r;
            borrow <= ~sum[SEG];
            ovf    <= v_ovf;
            lt     <= m ? (r_n ^ v_ovf) : ~sum[SEG];
            zero   <= (r == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_pipe.sv
// Directed bench for sub_pipe at WIDTH=16, SEG=8 (two-edge latency, falling-edge registers).
module tb_sub_pipe;

  logic        clk;
  logic        rst;
  logic        DV0;
  logic        stall;
  logic        signed_mode;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic        out_valid;
  logic [15:0] Result;
  logic        borrow;
  logic        lt;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  sub_pipe #(.WIDTH(16), .SEG(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .DV0         (DV0),
    .stall       (stall),
    .signed_mode (signed_mode),
    .in_A        (in_A),
    .in_B        (in_B),
    .out_valid   (out_valid),
    .Result      (Result),
    .borrow      (borrow),
    .lt          (lt),
    .ovf         (ovf),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic dv, input logic st, input logic sm,
                       input logic [15:0] a, input logic [15:0] b);
    rst         = r;
    DV0         = dv;
    stall       = st;
    signed_mode = sm;
    in_A        = a;
    in_B        = b;
  endtask

  // One active (falling) edge, then sample on the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags packed as {borrow, lt, ovf, zero}.
  task automatic expect_out(input string tag, input logic v, input logic [15:0] res,
                            input logic [3:0] fl);
    chk({tag, ".vld"}, {15'b0, out_valid}, {15'b0, v});
    chk({tag, ".res"}, Result, res);
    chk({tag, ".flg"}, {12'b0, borrow, lt, ovf, zero}, {12'b0, fl});
  endtask

  // Isolated operation: accept, check nothing yet, then check the result.
  task automatic single_op(input string tag, input logic sm, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] res, input logic [3:0] fl);
    drive(0, 1, 0, sm, a, b);
    step();
    chk({tag, ".early"}, {15'b0, out_valid}, 16'h0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out(tag, 1'b1, res, fl);
  endtask

  initial begin
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    step();
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("reset", 1'b0, 16'h0000, 4'b0000);

    single_op("basic", 0, 16'h1234, 16'h0034, 16'h1200, 4'b0000);
    step();
    expect_out("basic_hold", 1'b0, 16'h1200, 4'b0000);

    single_op("xseg", 0, 16'h0100, 16'h0001, 16'h00FF, 4'b0000);
    single_op("under", 0, 16'h0001, 16'h0002, 16'hFFFF, 4'b1100);
    single_op("sgn_ovf", 1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0110);
    single_op("uns_ovf", 0, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010);
    single_op("equal", 0, 16'hABCD, 16'hABCD, 16'h0000, 4'b0001);

    // Stream: O1, O2, bubble, O3 (signed), O4.
    drive(0, 1, 0, 0, 16'h0010, 16'h0001);
    step();
    chk("strm.e1", {15'b0, out_valid}, 16'h0000);
    drive(0, 1, 0, 0, 16'h0000, 16'h0001);
    step();
    expect_out("strm.o1", 1'b1, 16'h000F, 4'b0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("strm.o2", 1'b1, 16'hFFFF, 4'b1100);
    drive(0, 1, 0, 1, 16'h7FFF, 16'hFFFF);
    step();
    expect_out("strm.gap", 1'b0, 16'hFFFF, 4'b1100);
    drive(0, 1, 0, 0, 16'h5555, 16'h1111);
    step();
    expect_out("strm.o3", 1'b1, 16'h8000, 4'b1010);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("strm.o4", 1'b1, 16'h4444, 4'b0000);
    step();
    expect_out("strm.end", 1'b0, 16'h4444, 4'b0000);

    // Stall with OA at the output and OB in flight; OX offered during the stall.
    drive(0, 1, 0, 0, 16'h2000, 16'h1000);
    step();
    drive(0, 1, 0, 0, 16'h0300, 16'h0400);
    step();
    expect_out("stall.oa", 1'b1, 16'h1000, 4'b0000);
    drive(0, 1, 1, 1, 16'h9999, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stall.frz%0d", i), 1'b1, 16'h1000, 4'b0000);
    end
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("stall.ob", 1'b1, 16'hFF00, 4'b1100);
    step();
    expect_out("stall.nox1", 1'b0, 16'hFF00, 4'b1100);
    step();
    expect_out("stall.nox2", 1'b0, 16'hFF00, 4'b1100);

    // Reset at the edge after acceptance discards the operation.
    drive(0, 1, 0, 0, 16'h0005, 16'h0003);
    step();
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("rst_mid", 1'b0, 16'h0000, 4'b0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("rst_mid.after", 1'b0, 16'h0000, 4'b0000);

    // Reset together with stall, with a result at the output and one in flight.
    drive(0, 1, 0, 0, 16'h0005, 16'h0003);
    step();
    drive(0, 1, 0, 0, 16'h0003, 16'h0005);
    step();
    expect_out("rst_stl.pre", 1'b1, 16'h0002, 4'b0000);
    drive(1, 0, 1, 0, 16'h0000, 16'h0000);
    step();
    expect_out("rst_stl", 1'b0, 16'h0000, 4'b0000);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000);
    step();
    expect_out("rst_stl.after", 1'b0, 16'h0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_pipe.md
Name: sub_pipe

Overview:
- Parametrised, pipelined two's-complement subtractor: Result = in_A − in_B, split into SEG-bit segments with one segment per pipeline stage.
- Generalises the divider's fixed 16-bit single-register subtractor: any width, selectable signed/unsigned compare, registered borrow/overflow/zero flags, valid pipeline with stall.
- Sits in the divider datapath and in any block needing a high-width compare/subtract at full clock rate.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, segment width per pipeline stage; STAGES = WIDTH/SEG (1 allowed: single-cycle).

Ports:
- clk  in  1  clock; all registers update on the falling edge of clk (divider datapath convention).
- rst  in  1  synchronous active-high reset.
- DV0  in  1  input valid; operands are accepted on a clock edge where DV0=1 and stall=0.
- stall  in  1  freeze: all pipeline registers and outputs hold.
- signed_mode  in  1  1 = signed compare/overflow, 0 = unsigned; captured with the operands.
- in_A  in  WIDTH  minuend.
- in_B  in  WIDTH  subtrahend.
- out_valid  out  1  Result/flags valid for this cycle.
- Result  out  WIDTH  in_A − in_B modulo 2^WIDTH.
- borrow  out  1  1 when unsigned in_A < in_B.
- lt  out  1  in_A < in_B under the captured mode: unsigned = borrow; signed = N xor V.
- ovf  out  1  signed overflow (A, B sign differ and result sign ≠ A sign); valid in both modes.
- zero  out  1  Result == 0.

Behaviour:
- Reset (rst=1 at an edge, regardless of stall or DV0): all stage valids, carries, partial results and outputs clear to 0. out_valid=0, Result=0, all flags 0.
- Arithmetic: Result = in_A + ~in_B + 1.
  - Stage 0 computes segment 0 with carry-in 1.
  - Stage k computes segment k from delayed operand segments plus the registered carry-out of stage k−1.
  - Completed lower segments ride along in delay registers so all segments emerge aligned.
- Flags are computed from the final carry-out and MSBs in the last stage:
  - borrow = ~carry_out.
  - N = Result[WIDTH−1].
  - V from the sign bits of A, B and Result.
- Latency: exactly STAGES active (non-stalled) edges from acceptance to out_valid=1. Throughput: one operation per edge; back-to-back DV0 gives back-to-back out_valid.
- Bubbles: DV0=0 with stall=0 inserts an invalid slot that advances like data. Result and flags are not overwritten by invalid slots; they hold the last valid value. out_valid is high only on the cycle its slot reaches the output.
- Stall: with stall=1, every register holds, including out_valid. In that state DV0 is ignored, and an operand presented is not captured.
- Simultaneous stall=1 and rst=1: reset wins.
- Reset mid-operation: all in-flight operations are discarded; no out_valid is produced for them.
- signed_mode travels with its operands, so mixed-mode back-to-back operations are legal.
- No combinational path from any input to any output.

Test Plan (WIDTH=16, SEG=8, latency 2):
- 0x1234 − 0x0034, unsigned, DV0 pulse → 2 edges later: out_valid=1, Result=0x1200, borrow=0, lt=0, zero=0, ovf=0.
- Cross-segment borrow: 0x0100 − 0x0001 → Result=0x00FF, borrow=0; 0x0001 − 0x0002 → Result=0xFFFF, borrow=1, lt=1.
- Signed: 0x8000 − 0x0001, signed_mode=1 → Result=0x7FFF, ovf=1, lt=1, borrow=0; same operands with signed_mode=0 → lt=0.
- Equality and streaming: 0xABCD − 0xABCD → zero=1. Then stream 4 back-to-back ops with one DV0=0 bubble → 4 out_valid pulses in order with the bubble gap, and Result holds across the gap.
- Stall: assert stall for 3 edges with 2 ops in flight → outputs and out_valid frozen; results emerge in order after release, and no operand presented during the stall is captured.
- Reset mid-operation: rst at the edge after acceptance → no out_valid, all outputs 0. rst together with stall=1 → same cleared state.
